bit_pix_wr_sequencer: RTL and testbench

Front-end write controller for the bit-pixel BRAM feeding the block-matching pipeline. Accepts a stream of packed 16-bit census/bit-pixel words. Sequences them into the three image regions (left third, center, right third), with addresses and third index generated per region. Ping-pongs between two BRAM buffers, advances the image number, and drops frames whose target buffer is still being read by the block-match control FSM.

---
 rtl/bit_pix_wr_sequencer.sv | 175 +++++++++++++++++
 tb/tb_bit_pix_wr_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_pix_wr_sequencer.sv
// Write sequencer for the bit-pixel BRAM. Accepted words are laid out as
// left third, center, right third. Frames alternate between two buffers.
// A frame is dropped if its target buffer is still being read by block-match.
module bit_pix_wr_sequencer #(
   parameter int THIRD_WIDTH  = 240,
   parameter int CENTER_WIDTH = 304,
   parameter int THIRD_HEIGHT = 480,
   parameter int WORD_BITS    = 16
) (
   input  logic        clk50,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic        in_sof,
   output logic        in_ready,
   input  logic        bm_busy,
   input  logic        bm_working_buf,
   output logic [15:0] wr_address,
   output logic [1:0]  wr_third,
   output logic [15:0] wr_writedata,
   output logic        wr_write,
   output logic        buf_index,
   output logic [31:0] image_number,
   output logic        frame_done,
   output logic        frame_dropped
);

   localparam logic [15:0] THIRD_END  = 16'(THIRD_WIDTH * THIRD_HEIGHT / WORD_BITS);
   localparam logic [15:0] CENTER_END = 16'(CENTER_WIDTH * THIRD_HEIGHT / WORD_BITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] word_addr_q, word_addr_d;
   logic [1:0]  region_q, region_d;
   logic        buf_q, buf_d;
   logic [31:0] image_q, image_d;
   logic        ready_q;
   logic        wr_write_q, wr_write_d;
   logic [15:0] wr_address_q, wr_address_d;
   logic [1:0]  wr_third_q, wr_third_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        done_q, done_d;
   logic        dropped_q, dropped_d;

   logic        accept;
   logic        buf_free;
   logic        mid_frame;
   logic [15:0] end_addr;

   assign accept    = in_valid & ready_q;
   assign buf_free  = ~bm_busy | (bm_working_buf != buf_q);
   assign mid_frame = (word_addr_q != 16'd0) | (region_q != 2'd0);
   assign end_addr  = (region_q == 2'd1) ? CENTER_END : THIRD_END;

   // State, counters and registered write-port outputs.
   always_ff @(posedge clk50) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         word_addr_q  <= 16'd0;
         region_q     <= 2'd0;
         buf_q        <= 1'b0;
         image_q      <= 32'd0;
         ready_q      <= 1'b0;
         wr_write_q   <= 1'b0;
         wr_address_q <= 16'd0;
         wr_third_q   <= 2'd0;
         wr_data_q    <= 16'd0;
         done_q       <= 1'b0;
         dropped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_addr_q  <= word_addr_d;
         region_q     <= region_d;
         buf_q        <= buf_d;
         image_q      <= image_d;
         ready_q      <= 1'b1;
         wr_write_q   <= wr_write_d;
         wr_address_q <= wr_address_d;
         wr_third_q   <= wr_third_d;
         wr_data_q    <= wr_data_d;
         done_q       <= done_d;
         dropped_q    <= dropped_d;
      end
   end

   // Next-state: frame start/abort decisions and address/region sequencing.
   always_comb begin
      state_d      = state_q;
      word_addr_d  = word_addr_q;
      region_d     = region_q;
      buf_d        = buf_q;
      image_d      = image_q;
      wr_write_d   = 1'b0;
      wr_address_d = wr_address_q;
      wr_third_d   = wr_third_q;
      wr_data_d    = wr_data_q;
      done_d       = 1'b0;
      dropped_d    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DROP: begin
            if (accept && in_sof) begin
               if (buf_free) begin
                  // First word of a frame always lands at offset 0 of region 0.
                  wr_write_d   = 1'b1;
                  wr_address_d = buf_q ? THIRD_END : 16'd0;
                  wr_third_d   = 2'd0;
                  wr_data_d    = in_data;
                  word_addr_d  = 16'd1;
                  region_d     = 2'd0;
                  state_d      = ST_WRITE;
               end else begin
                  dropped_d = 1'b1;
                  state_d   = ST_DROP;
               end
            end
         end
         ST_WRITE: begin
            if (accept) begin
               if (in_sof && mid_frame) begin
                  // Abort the partial frame; the sof word restarts the same buffer.
                  dropped_d = 1'b1;
                  region_d  = 2'd0;
                  if (buf_free) begin
                     wr_write_d   = 1'b1;
                     wr_address_d = buf_q ? THIRD_END : 16'd0;
                     wr_third_d   = 2'd0;
                     wr_data_d    = in_data;
                     word_addr_d  = 16'd1;
                  end else begin
                     word_addr_d = 16'd0;
                     state_d     = ST_DROP;
                  end
               end else begin
                  wr_write_d   = 1'b1;
                  wr_address_d = buf_q ? (end_addr + word_addr_q) : word_addr_q;
                  wr_third_d   = region_q;
                  wr_data_d    = in_data;
                  if (word_addr_q == end_addr - 16'd1) begin
                     word_addr_d = 16'd0;
                     if (region_q == 2'd2) begin
                        region_d = 2'd0;
                        buf_d    = ~buf_q;
                        image_d  = image_q + 32'd1;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                     end else begin
                        region_d = region_q + 2'd1;
                     end
                  end else begin
                     word_addr_d = word_addr_q + 16'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready      = ready_q;
   assign wr_write      = wr_write_q;
   assign wr_address    = wr_address_q;
   assign wr_third      = wr_third_q;
   assign wr_writedata  = wr_data_q;
   assign buf_index     = buf_q;
   assign image_number  = image_q;
   assign frame_done    = done_q;
   assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_bit_pix_wr_sequencer.sv
// Scoreboard bench for bit_pix_wr_sequencer: stimulus pushes the expected
// BRAM writes, a negedge monitor pops and compares each presented write.
module tb_bit_pix_wr_sequencer;

   logic        clk50 = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in_data = 16'd0;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic        bm_busy = 1'b0;
   logic        bm_working_buf = 1'b0;
   logic [15:0] wr_address;
   logic [1:0]  wr_third;
   logic [15:0] wr_writedata;
   logic        wr_write;
   logic        buf_index;
   logic [31:0] image_number;
   logic        frame_done;
   logic        frame_dropped;

   bit_pix_wr_sequencer dut (
      .clk50(clk50), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
      .bm_busy(bm_busy), .bm_working_buf(bm_working_buf),
      .wr_address(wr_address), .wr_third(wr_third), .wr_writedata(wr_writedata),
      .wr_write(wr_write), .buf_index(buf_index), .image_number(image_number),
      .frame_done(frame_done), .frame_dropped(frame_dropped)
   );

   always #5 clk50 = ~clk50;

   typedef struct packed {
      logic [15:0] addr;
      logic [1:0]  third;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  pass_cnt = 0;
   int  total_cnt = 0;
   int  done_cnt = 0;
   int  drop_cnt = 0;
   int  wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Monitor: pop and compare every write the DUT presents.
   always @(negedge clk50) begin
      if (reset) begin
         if (wr_write) begin
            wr_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_write: got addr=%0d third=%0d data=%h expected no write",
                        wr_address, wr_third, wr_writedata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (wr_address === e.addr && wr_third === e.third && wr_writedata === e.data)
                  pass_cnt++;
               else
                  $display("FAIL write: got addr=%0d third=%0d data=%h expected addr=%0d third=%0d data=%h",
                           wr_address, wr_third, wr_writedata, e.addr, e.third, e.data);
            end
         end
         if (frame_done) begin
            done_cnt++;
            check("done_with_last_write", {31'd0, wr_write}, 32'd1);
         end
         if (frame_dropped) drop_cnt++;
      end
   end

   // Expected write for word k of a frame into buffer b.
   function automatic wr_t exp_of(input int k, input logic b, input logic [15:0] d);
      wr_t e;
      int  t, off, base;
      if (k < 7200) begin t = 0; off = k; end
      else if (k < 16320) begin t = 1; off = k - 7200; end
      else begin t = 2; off = k - 16320; end
      base = b ? ((t == 1) ? 9120 : 7200) : 0;
      e.addr  = 16'(base + off);
      e.third = 2'(t);
      e.data  = d;
      return e;
   endfunction

   task automatic send(input logic [15:0] d, input logic sof, input int gap);
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      @(posedge clk50); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (gap) begin @(posedge clk50); #1; end
   endtask

   // Send words [from,to) of a frame; word 0 carries sof.
   task automatic frame_words(input int from, input int to, input logic b, input int fid,
                              input int gap_lo, input int gap_hi, input logic expect_wr);
      for (int k = from; k < to; k++) begin
         logic [15:0] d;
         d = 16'(k * 37 + fid * 1000);
         if (expect_wr) exp_q.push_back(exp_of(k, b, d));
         send(d, (k == 0), (k >= gap_lo && k < gap_hi) ? 2 : 0);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      @(negedge clk50); #1;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk50); #1;
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_wr_write"}, {31'd0, wr_write}, 32'd0);
      check({tag, "_wr_address"}, {16'd0, wr_address}, 32'd0);
      check({tag, "_wr_third"}, {30'd0, wr_third}, 32'd0);
      check({tag, "_wr_data"}, {16'd0, wr_writedata}, 32'd0);
      check({tag, "_buf"}, {31'd0, buf_index}, 32'd0);
      check({tag, "_image"}, image_number, 32'd0);
      check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_dropped"}, {31'd0, frame_dropped}, 32'd0);
   endtask

   initial begin
      int drop0, wr0;
      // Power-up reset.
      repeat (3) @(posedge clk50);
      @(negedge clk50); #1;
      check_outputs_zero("reset0");
      @(posedge clk50); #1;
      reset = 1'b1;
      repeat (2) begin @(posedge clk50); #1; end
      check("ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Reset in the middle of a frame at word 12000.
      frame_words(0, 12000, 1'b0, 1, 0, 0, 1'b1);
      wait_drain("drain_pre_reset");
      @(posedge clk50); #1;
      reset = 1'b0;
      @(posedge clk50); #1;
      @(negedge clk50); #1;
      check_outputs_zero("midreset");
      @(posedge clk50); #1;
      reset = 1'b1;
      repeat (2) begin @(posedge clk50); #1; end
      wr0 = wr_cnt;
      for (int i = 0; i < 5; i++) send(16'(16'hA000 + i), 1'b0, 0);
      repeat (3) begin @(posedge clk50); #1; end
      check("no_write_non_sof", 32'(wr_cnt), 32'(wr0));
      check("image_after_reset", image_number, 32'd0);
      check("buf_after_reset", {31'd0, buf_index}, 32'd0);

      // Frame A into buffer 0, gapped across the region 0/1 boundary.
      frame_words(0, 23520, 1'b0, 2, 7190, 7210, 1'b1);
      wait_drain("drain_frame_a");
      check("done_cnt_a", 32'(done_cnt), 32'd1);
      check("image_a", image_number, 32'd1);
      check("buf_a", {31'd0, buf_index}, 32'd1);

      // Frame B into buffer 1 while block-match reads buffer 0 (no contention).
      bm_busy = 1'b1;
      bm_working_buf = 1'b0;
      frame_words(0, 23520, 1'b1, 3, 0, 0, 1'b1);
      wait_drain("drain_frame_b");
      check("done_cnt_b", 32'(done_cnt), 32'd2);
      check("image_b", image_number, 32'd2);
      check("buf_b", {31'd0, buf_index}, 32'd0);

      // Contention: buffer 0 busy, frame must be dropped.
      drop0 = drop_cnt;
      wr0 = wr_cnt;
      frame_words(0, 100, 1'b0, 4, 0, 0, 1'b0);
      repeat (3) begin @(posedge clk50); #1; end
      check("drop_contention", 32'(drop_cnt), 32'(drop0 + 1));
      check("no_write_contention", 32'(wr_cnt), 32'(wr0));
      check("image_contention", image_number, 32'd2);

      // Buffer freed: resume at address 0, then mid-frame sof at word 5000.
      bm_busy = 1'b0;
      drop0 = drop_cnt;
      frame_words(0, 5000, 1'b0, 5, 0, 0, 1'b1);
      wait_drain("drain_partial");
      check("image_partial", image_number, 32'd2);
      frame_words(0, 23520, 1'b0, 6, 0, 0, 1'b1);
      wait_drain("drain_restart");
      check("drop_midframe", 32'(drop_cnt), 32'(drop0 + 1));
      check("done_cnt_final", 32'(done_cnt), 32'd3);
      check("image_final", image_number, 32'd3);
      check("buf_final", {31'd0, buf_index}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
